// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : E-stage HI/LO multiply/divide responder (start/busy handshake)
// Optional: define MDU_MADD_EN for madd/maddu/msub/msubu accumulate ops.
// Revision: 1.0  initial release
// ============================================================================
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic        is_mult;
  logic        is_div;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_ovf;
  logic        div_zero;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [63:0] next_hilo;

`ifdef MDU_MADD_EN
  assign is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU) ||
                   (MDOp >= OP_MADD && MDOp <= OP_MSUBU);
`else
  assign is_mult = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
`endif
  assign is_div  = (MDOp == OP_DIV) || (MDOp == OP_DIVU);

  // Results come only from the latched operands, so A/B may change during RUN.
  assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u   = {32'b0, a_q} * {32'b0, b_q};
  assign div_zero = (b_q == 32'd0);
  // The one signed quotient that does not fit in 32 bits is pinned explicitly.
  assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign quo_s    = div_ovf ? 32'h8000_0000 : 32'($signed(a_q) / $signed(b_q));
  assign rem_s    = div_ovf ? 32'd0         : 32'($signed(a_q) % $signed(b_q));
  assign quo_u    = a_q / b_q;
  assign rem_u    = a_q % b_q;

  always_comb begin
    next_hilo = {HI, LO};
    case (op_q)
      OP_MULT:  next_hilo = prod_s;
      OP_MULTU: next_hilo = prod_u;
      OP_DIV:   if (!div_zero) next_hilo = {rem_s, quo_s};
      OP_DIVU:  if (!div_zero) next_hilo = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  next_hilo = {HI, LO} + prod_s;
      OP_MADDU: next_hilo = {HI, LO} + prod_u;
      OP_MSUB:  next_hilo = {HI, LO} - prod_s;
      OP_MSUBU: next_hilo = {HI, LO} - prod_u;
`endif
      default:  next_hilo = {HI, LO};
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (is_mult || is_div) begin
              op_q  <= MDOp;
              a_q   <= A;
              b_q   <= B;
              cnt   <= is_div ? DIV_LAT : MULT_LAT;
              busy  <= 1'b1;
              state <= RUN;
            end else if (MDOp == OP_MTHI) begin
              HI <= A;
            end else if (MDOp == OP_MTLO) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          // start is deliberately not looked at here: issues during RUN are dropped.
          if (cnt == 4'd1) begin
            {HI, LO} <= next_hilo;
            busy     <= 1'b0;
            cnt      <= 4'd0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// tb_mul_div_unit : directed self-checking bench for mul_div_unit
// Revision: 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .MDOp(MDOp),
    .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 Clk = ~Clk;

  // Reference model: result arithmetic done with 64-bit integers, timing as
  // "operation issued at cycle T is busy until cycle T+N, then commits".
  longint unsigned cyc = 0;
  bit              m_pend = 1'b0;
  longint unsigned m_end = 0;
  logic [3:0]      m_op = 4'd0;
  logic [31:0]     m_a = 32'd0, m_b = 32'd0;
  logic [63:0]     m_hilo = 64'd0;

  function automatic bit op_accepted(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] result(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hilo);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [63:0] q, r;
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return hilo;
        q = 64'(sa / sb); r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return hilo;
        q = ua / ub; r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      4'd7:  return hilo + 64'(sa * sb);
      4'd8:  return hilo + ua * ub;
      4'd9:  return hilo - 64'(sa * sb);
      4'd10: return hilo - ua * ub;
      default: return hilo;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_pend <= 1'b0;
      m_hilo <= 64'd0;
    end else if (m_pend) begin
      if (cyc == m_end) begin
        m_hilo <= result(m_op, m_a, m_b, m_hilo);
        m_pend <= 1'b0;
      end
    end else if (start) begin
      if (op_accepted(MDOp)) begin
        m_pend <= 1'b1;
        m_end  <= cyc + ((MDOp == 4'd3 || MDOp == 4'd4) ? DIV_N : MULT_N);
        m_op   <= MDOp;
        m_a    <= A;
        m_b    <= B;
      end else if (MDOp == 4'd5) begin
        m_hilo[63:32] <= A;
      end else if (MDOp == 4'd6) begin
        m_hilo[31:0] <= A;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      checks++;
      if (busy !== m_pend || HI !== m_hilo[63:32] || LO !== m_hilo[31:0]) begin
        errors++;
        $display("FAIL model cyc=%0d got busy=%b HI=%h LO=%h expected busy=%b HI=%h LO=%h",
                 cyc, busy, HI, LO, m_pend, m_hilo[63:32], m_hilo[31:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Issue one op (start for one cycle) and count busy cycles, bounded.
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    @(negedge Clk);
    start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge Clk);
    start = 1'b0; A = ~a; B = ~b;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge Clk);
    end
    chk({name, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    chk({name, "_HI"}, HI, exp_hi);
    chk({name, "_LO"}, LO, exp_lo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    cmp_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);

    run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'h2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'h2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 4'd4, 32'd7, 32'd0, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 4'd4, 32'd100, 32'd7, DIV_N, 32'd2, 32'd14);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000);
    run_op("div_neg", 4'd3, 32'd7, 32'hFFFF_FFFE, DIV_N, 32'd1, 32'hFFFF_FFFD);
    run_op("mthi", 4'd5, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'hFFFF_FFFD);
    run_op("mtlo", 4'd6, 32'hCAFE_BABE, 32'd0, 0, 32'h1234_5678, 32'hCAFE_BABE);
    run_op("nop0", 4'd0, 32'h1111_1111, 32'd3, 0, 32'h1234_5678, 32'hCAFE_BABE);
    run_op("nop11", 4'd11, 32'h2222_2222, 32'd3, 0, 32'h1234_5678, 32'hCAFE_BABE);

    // mult issued, then an mtlo pulse at cycle 2 that must be ignored
    @(negedge Clk);
    start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd5;
    @(negedge Clk);
    start = 1'b0; A = 32'd0; B = 32'd0;
    @(negedge Clk);
    start = 1'b1; MDOp = 4'd6;
    @(negedge Clk);
    start = 1'b0;
    n = 2;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge Clk);
    end
    chk("ignore_busy_cycles", 32'(n), 32'(MULT_N));
    chk("ignore_HI", HI, 32'd0);
    chk("ignore_LO", LO, 32'd15);

    // reset in the middle of a divide
    @(negedge Clk);
    start = 1'b1; MDOp = 4'd3; A = 32'd100; B = 32'd7;
    @(negedge Clk);
    start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    run_op("post_rst_mult", 4'd1, 32'd3, 32'd4, MULT_N, 32'd0, 32'd12);

`ifdef MDU_MADD_EN
    run_op("pre_hi", 4'd5, 32'd0, 32'd0, 0, 32'd0, 32'd12);
    run_op("pre_lo", 4'd6, 32'd0, 32'd0, 0, 32'd0, 32'd0);
    run_op("maddu", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_N, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("msub", 4'd9, 32'd1, 32'd2, MULT_N, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_op("madd", 4'd7, 32'hFFFF_FFFF, 32'd1, MULT_N, 32'hFFFF_FFFD, 32'hFFFF_FFFE);
    run_op("msubu", 4'd10, 32'hFFFF_FFFF, 32'd1, MULT_N, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
`else
    run_op("madd_off", 4'd7, 32'd9, 32'd9, 0, 32'd0, 32'd12);
    run_op("msubu_off", 4'd10, 32'd9, 32'd9, 0, 32'd0, 32'd12);
`endif

    @(negedge Clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
